// File: rtl/riscv_fetch_pkg.sv
// Shared fetch-stage types and constants.
// A fetch entry pairs an instruction with the PC it was fetched from.
package riscv_fetch_pkg;

  localparam int              XLEN        = 32;
  localparam int              INSTR_BYTES = 4;
  localparam logic [XLEN-1:0] RESET_PC    = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetch entries with flush; no read bypass, head is visible the cycle after push.
// Caller guarantees no push when full unless popping, and no pop when empty.
module fetch_queue
  import riscv_fetch_pkg::*;
#(
  parameter int  DEPTH   = 2,
  parameter type entry_t = fetch_entry_t,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  entry_t        wr_entry,
  output entry_t        rd_entry,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  entry_t          mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (!push && pop) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= wr_entry;
  end

  assign rd_entry = mem_q[rd_ptr_q];
  assign full     = (count_q == (AW+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch PC, instruction-memory address drive and decode handshake around a small fetch queue.
// Redirect flushes the queue and reloads the PC; halt freezes the PC while the queue drains.
module instr_fetch_unit #(
  parameter int              XLEN     = riscv_fetch_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = riscv_fetch_pkg::RESET_PC,
  parameter int              DEPTH    = 2,
  localparam int             CW       = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            reset,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            halt,
  output logic            dec_valid,
  input  logic            dec_ready,
  output logic [XLEN-1:0] dec_instr,
  output logic [XLEN-1:0] dec_pc,
  output logic [CW-1:0]   queue_count,
  output logic            misalign_err
);
  import riscv_fetch_pkg::*;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } entry_t;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic            misalign_q, misalign_d;
  logic            push, pop, q_full, q_empty;
  entry_t          wr_entry, head;

  // Redirect overrides everything: no pop, no push, PC reload.
  assign pop      = dec_valid & dec_ready & ~redirect_valid;
  assign push     = ~redirect_valid & ~halt & (~q_full | pop);
  assign wr_entry = '{pc: fetch_pc_q, instr: imem_data};

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    misalign_d = 1'b0;
    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
      misalign_d = |redirect_pc[1:0];
    end else if (push) begin
      fetch_pc_d = fetch_pc_q + XLEN'(INSTR_BYTES);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      misalign_q <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      misalign_q <= misalign_d;
    end
  end

  fetch_queue #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fetch_queue (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .pop      (pop),
    .flush    (redirect_valid),
    .wr_entry (wr_entry),
    .rd_entry (head),
    .full     (q_full),
    .empty    (q_empty),
    .count    (queue_count)
  );

  assign imem_addr    = fetch_pc_q;
  assign dec_valid    = ~q_empty;
  assign dec_instr    = dec_valid ? head.instr : '0;
  assign dec_pc       = dec_valid ? head.pc    : '0;
  assign misalign_err = misalign_q;

endmodule
